// File: rtl/video_dram_seq.sv
// ---------------------------------------------------------------------------
// video_dram_seq
// Video DRAM burst sequencer. Turns a level fetch request from video_top
// (video_go / video_addr / video_bw) into slot-timed DRAM read requests,
// and returns the pre_next / next / strobe handshakes together with the
// registered read word.
//
// Ports
//   clk, res_n          system clock, asynchronous active-low reset
//   c2, c3              DRAM slot phases (c3 = last clk of a 4-clk slot)
//   video_go            fetch request (level)
//   video_addr          burst start word address, sampled at burst start
//   video_bw            [4:3] density (1/2/4/8 slots of 8), [2:0] length-1
//   dram_req/dram_addr  request and word address for the current slot
//   dram_ack            arbiter grant, meaningful only on c3
//   dram_rdata          raw DRAM read data
//   video_pre_next      request pending, grant decided next clk
//   video_next          1-clk pulse on c3 when a word is granted
//   video_strobe        1-clk pulse, video_rdata valid
//   video_rdata         registered read word
//   busy                burst active or reads outstanding
//   state_dbg           1 while the FSM is in BURST
//   stat_clr, miss_cnt  only with VIDEO_SEQ_STAT_EN defined: missed-grant
//                       counter (saturating at 255) and its synchronous clear
//
// Handshake: a word is transferred on a clk where c3 & dram_req & dram_ack
// are all high; dram_req/dram_addr are stable for the whole slot, and a
// dropped video_go withdraws dram_req in the same clk.
//
// RD_LAT legal range is 1..15.
// ---------------------------------------------------------------------------
module video_dram_seq #(
  parameter int RD_LAT = 4,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              c2,
  input  logic              c3,
  input  logic              video_go,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic [4:0]        video_bw,
  output logic              dram_req,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic              dram_ack,
  input  logic [15:0]       dram_rdata,
  output logic              video_pre_next,
  output logic              video_next,
  output logic              video_strobe,
  output logic [15:0]       video_rdata,
  output logic              busy,
  output logic              state_dbg
`ifdef VIDEO_SEQ_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [7:0]        miss_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          slot_cnt;
  logic                armed;
  logic [ADDR_W-1:0]   addr;
  logic [3:0]          left;
  logic [1:0]          dens;
  logic [RD_LAT-1:0]   pipe;
  logic                eligible;
  logic                start;
  logic                grant;

  // Density selects which of the 8 slots in a slot_cnt cycle may carry a
  // request: the last one, every 4th, every 2nd or every slot.
  always_comb begin
    eligible = 1'b0;
    case (dens)
      2'b00:   eligible = (slot_cnt == 3'd7);
      2'b01:   eligible = (slot_cnt[1:0] == 2'b11);
      2'b10:   eligible = slot_cnt[0];
      default: eligible = 1'b1;
    endcase
  end

  assign dram_req       = (state == BURST) & eligible & video_go;
  assign dram_addr      = addr;
  assign grant          = c3 & dram_req & dram_ack;
  assign start          = (state == IDLE) & c3 & video_go & armed;
  assign video_pre_next = dram_req & c2;
  assign video_next     = grant;
  assign busy           = (state != IDLE) | (|pipe) | video_strobe;
  assign state_dbg      = (state == BURST);

  // FSM state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state. Decisions are only taken on c3, the arbiter sample point.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = BURST;
      end
      BURST: begin
        if (c3) begin
          if (!video_go)                     state_nxt = IDLE;
          else if (grant && left == 4'd1)    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot counter, burst parameters and re-arm flag
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      slot_cnt <= 3'd0;
      armed    <= 1'b1;
      addr     <= '0;
      left     <= 4'd0;
      dens     <= 2'b00;
    end else begin
      if (c3) slot_cnt <= slot_cnt + 3'd1;

      // A held video_go never restarts a burst; it must be seen low first.
      if (!video_go)  armed <= 1'b1;
      else if (start) armed <= 1'b0;

      if (start) begin
        addr <= video_addr;
        left <= {1'b0, video_bw[2:0]} + 4'd1;
        dens <= video_bw[4:3];
      end else if (grant) begin
        addr <= addr + ADDR_W'(1);
        left <= left - 4'd1;
      end
    end
  end

  // Read pipe: one bit per granted word, shifted every clk. The data is
  // valid while the grant sits in the last stage. Reads keep draining after
  // the FSM has left BURST; only reset drops them.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pipe         <= '0;
      video_strobe <= 1'b0;
      video_rdata  <= 16'h0000;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0]      <= grant;
      video_strobe <= pipe[RD_LAT-1];
      if (pipe[RD_LAT-1]) video_rdata <= dram_rdata;
    end
  end

`ifdef VIDEO_SEQ_STAT_EN
  // Missed-grant counter; clear takes priority over a same-clk miss.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                                          miss_cnt <= 8'd0;
    else if (stat_clr)                                   miss_cnt <= 8'd0;
    else if (c3 && dram_req && !dram_ack && miss_cnt != 8'hFF)
                                                         miss_cnt <= miss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_video_dram_seq.sv
// ---------------------------------------------------------------------------
// tb_video_dram_seq
// Self-checking bench for video_dram_seq. Slot phases are generated by the
// bench; a transaction-level reference model (burst start/length, slot
// eligibility as slot % period arithmetic, timestamped read queue) predicts
// every output each clk. Directed scenarios are followed by a randomized
// phase. Define VIDEO_SEQ_STAT_EN to also cover the miss counter.
// ---------------------------------------------------------------------------
module tb_video_dram_seq;
  localparam int RD_LAT = 4;
  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              res_n;
  logic              c2, c3;
  logic              video_go;
  logic [ADDR_W-1:0] video_addr;
  logic [4:0]        video_bw;
  logic              dram_req;
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_ack;
  logic [15:0]       dram_rdata;
  logic              video_pre_next, video_next, video_strobe;
  logic [15:0]       video_rdata;
  logic              busy, state_dbg;
`ifdef VIDEO_SEQ_STAT_EN
  logic              stat_clr;
  logic [7:0]        miss_cnt;
  int                m_miss;
  logic              nxt_clr, p_clr;
`endif

  video_dram_seq #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .res_n(res_n), .c2(c2), .c3(c3),
    .video_go(video_go), .video_addr(video_addr), .video_bw(video_bw),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_ack(dram_ack),
    .dram_rdata(dram_rdata), .video_pre_next(video_pre_next),
    .video_next(video_next), .video_strobe(video_strobe),
    .video_rdata(video_rdata), .busy(busy), .state_dbg(state_dbg)
`ifdef VIDEO_SEQ_STAT_EN
    , .stat_clr(stat_clr), .miss_cnt(miss_cnt)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int                cyc, phase, m_slot, m_left, m_period;
  bit                m_active, m_armed;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_rdata;
  int                due_q[$];
  logic [15:0]       exp_q[$];

  // previous-clk inputs and expectation, consumed at the next edge
  logic              p_go, p_c3, p_ack, p_req;
  logic [ADDR_W-1:0] p_addr;
  logic [4:0]        p_bw;
  logic [15:0]       p_rdata;

  // stimulus controls
  logic              nxt_go, nxt_res;
  logic [ADDR_W-1:0] nxt_addr;
  logic [4:0]        nxt_bw;
  int                ack_mode, deny_cnt;

  // observation counters
  int                obs_next, obs_strobe, obs_pre, obs_req_c3;
  logic [ADDR_W-1:0] gaddr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    obs_next = 0; obs_strobe = 0; obs_pre = 0; obs_req_c3 = 0;
    gaddr_q.delete();
  endtask

  task automatic model_reset();
    m_active = 0; m_armed = 1; m_slot = 0; m_left = 0; m_period = 8;
    m_addr = '0; m_rdata = 16'h0; phase = 0;
    due_q.delete(); exp_q.delete();
    p_go = 0; p_c3 = 0; p_ack = 0; p_req = 0; p_addr = '0; p_bw = '0; p_rdata = '0;
`ifdef VIDEO_SEQ_STAT_EN
    m_miss = 0; p_clr = 0;
`endif
  endtask

  // Advance the model across the edge that ends clk number cyc.
  task automatic model_edge();
    if (due_q.size() > 0 && due_q[0] == cyc) due_q.delete(0);
`ifdef VIDEO_SEQ_STAT_EN
    if (p_clr) m_miss = 0;
    else if (p_c3 && p_req && !p_ack && m_miss < 255) m_miss++;
`endif
    if (p_c3) begin
      if (m_active) begin
        if (!p_go) m_active = 0;
        else if (p_req && p_ack) begin
          due_q.push_back(cyc + RD_LAT + 1);
          m_addr = m_addr + 1'b1;
          m_left--;
          if (m_left == 0) m_active = 0;
        end
      end else if (p_go && m_armed) begin
        m_active = 1;
        m_addr   = p_addr;
        m_left   = int'(p_bw[2:0]) + 1;
        m_period = 8 >> p_bw[4:3];
        m_armed  = 0;
      end
      m_slot = (m_slot + 1) % 8;
    end
    if (!p_go) m_armed = 1;
    // the word for a strobe due next clk is the data present this clk
    if (due_q.size() > 0 && due_q[0] == cyc + 1) exp_q.push_back(p_rdata);
  endtask

  // One clk: update model at the edge, drive new inputs, check outputs.
  task automatic tick();
    logic exp_req, exp_strobe;
    @(posedge clk);
    if (res_n) model_edge();
    cyc++;
    #1;
    if (!res_n) begin
      if (nxt_res) res_n = 1'b1;
      phase = 0;
    end else begin
      phase = (phase + 1) % 4;
    end
    c2         = (phase == 2);
    c3         = (phase == 3);
    video_go   = nxt_go;
    video_addr = nxt_addr;
    video_bw   = nxt_bw;
    dram_rdata = 16'($urandom);
`ifdef VIDEO_SEQ_STAT_EN
    stat_clr   = nxt_clr;
`endif
    exp_req = res_n && m_active && video_go && ((m_slot % m_period) == m_period - 1);
    dram_ack = 1'($urandom_range(0, 1));
    if (exp_req && c3) begin
      if (deny_cnt > 0) begin dram_ack = 1'b0; deny_cnt--; end
      else if (ack_mode == 0) dram_ack = 1'b1;
    end
    exp_strobe = (due_q.size() > 0 && due_q[0] == cyc);
    if (exp_strobe) begin
      if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      else chk("sb_underflow", 32'd1, 32'd0);
    end
    #1;
    chk("req",      dram_req,       exp_req);
    chk("addr",     dram_addr,      m_addr);
    chk("pre_next", video_pre_next, exp_req && c2);
    chk("next",     video_next,     exp_req && c3 && dram_ack);
    chk("strobe",   video_strobe,   exp_strobe);
    chk("rdata",    video_rdata,    m_rdata);
    chk("busy",     busy,           m_active || due_q.size() > 0);
    chk("state",    state_dbg,      m_active);
`ifdef VIDEO_SEQ_STAT_EN
    chk("miss_cnt", miss_cnt,       m_miss);
`endif
    if (video_next) begin obs_next++; gaddr_q.push_back(dram_addr); end
    if (video_strobe)   obs_strobe++;
    if (video_pre_next) obs_pre++;
    if (dram_req && c3) obs_req_c3++;
    p_go = video_go; p_c3 = c3; p_ack = dram_ack; p_req = exp_req;
    p_addr = video_addr; p_bw = video_bw; p_rdata = dram_rdata;
`ifdef VIDEO_SEQ_STAT_EN
    p_clr = stat_clr;
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // wait for the model to start a burst and then drain completely
  task automatic run_burst(input int max);
    bit started = 0;
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (m_active) started = 1;
      if (started && !m_active && due_q.size() == 0) done = 1;
    end
    chk("burst_timeout", done, 1'b1);
  endtask

  task automatic wait_quiet(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (!m_active && due_q.size() == 0) done = 1;
    end
    chk("quiet_timeout", done, 1'b1);
  endtask

  task automatic wait_next(input int n, input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (obs_next >= n) done = 1;
    end
    chk("next_timeout", done, 1'b1);
  endtask

  task automatic async_reset();
    #1;
    res_n = 1'b0;
    nxt_res = 1'b0;
    #1;
    model_reset();
    chk("rst_req",    dram_req,       1'b0);
    chk("rst_next",   video_next,     1'b0);
    chk("rst_pre",    video_pre_next, 1'b0);
    chk("rst_strobe", video_strobe,   1'b0);
    chk("rst_rdata",  video_rdata,    16'h0);
    chk("rst_busy",   busy,           1'b0);
    chk("rst_addr",   dram_addr,      '0);
    chk("rst_state",  state_dbg,      1'b0);
  endtask

  logic [ADDR_W-1:0] a;

  initial begin
    // reset
    res_n = 1'b0; c2 = 0; c3 = 0; video_go = 0; video_addr = '0; video_bw = '0;
    dram_ack = 0; dram_rdata = '0; cyc = 0;
    nxt_go = 0; nxt_res = 0; nxt_addr = '0; nxt_bw = '0; ack_mode = 0; deny_cnt = 0;
`ifdef VIDEO_SEQ_STAT_EN
    stat_clr = 0; nxt_clr = 0;
`endif
    model_reset();
    clr_obs();
    #2;
    async_reset();
    ticks(2);
    nxt_res = 1'b1;
    ticks(3);

    // 4-word burst at full density across a 64K boundary, always granted
    clr_obs();
    nxt_addr = 21'h1FFFE; nxt_bw = {2'b11, 3'd3}; nxt_go = 1; ack_mode = 0;
    run_burst(200);
    chk("t1_nexts",   obs_next,   4);
    chk("t1_strobes", obs_strobe, 4);
    for (int i = 0; i < 4; i++)
      chk("t1_gaddr", (i < gaddr_q.size()) ? gaddr_q[i] : 'x, 21'h1FFFE + i);
    nxt_go = 0; tick();

    // single word at lowest density
    clr_obs();
    nxt_addr = 21'($urandom); nxt_bw = {2'b00, 3'd0}; nxt_go = 1;
    run_burst(200);
    chk("t2_nexts",   obs_next,   1);
    chk("t2_pre",     obs_pre,    1);
    chk("t2_strobes", obs_strobe, 1);
    nxt_go = 0; tick();

    // two words at density 01, first grant withheld -> retry same address
    clr_obs();
    a = 21'($urandom);
    nxt_addr = a; nxt_bw = {2'b01, 3'd1}; nxt_go = 1; deny_cnt = 1;
    run_burst(300);
    chk("t3_req_c3", obs_req_c3, 3);
    chk("t3_nexts",  obs_next,   2);
    chk("t3_gaddr0", (gaddr_q.size() > 0) ? gaddr_q[0] : 'x, a);
    chk("t3_gaddr1", (gaddr_q.size() > 1) ? gaddr_q[1] : 'x, a + 1'b1);
`ifdef VIDEO_SEQ_STAT_EN
    chk("t3_miss", miss_cnt, 8'd1);
    nxt_clr = 1; tick(); nxt_clr = 0;
`endif
    nxt_go = 0; tick();

    // abort after 2 of 8 grants
    clr_obs();
    nxt_addr = 21'($urandom); nxt_bw = {2'b11, 3'd7}; nxt_go = 1;
    wait_next(2, 100);
    nxt_go = 0;
    wait_quiet(100);
    chk("t4_nexts",   obs_next,   2);
    chk("t4_strobes", obs_strobe, 2);
    chk("t4_busy",    busy,       1'b0);

    // held go does not restart; a 1-clk low pulse re-arms
    clr_obs();
    nxt_addr = 21'($urandom); nxt_bw = {2'b11, 3'd0}; nxt_go = 1;
    run_burst(100);
    ticks(40);
    chk("t5_no_restart", obs_next, 1);
    nxt_go = 0; tick();
    nxt_go = 1; nxt_addr = 21'($urandom);
    run_burst(100);
    chk("t5_restart", obs_next, 2);
    nxt_go = 0; tick();

    // randomized bursts, random grants, aborts and back-to-back starts
    ack_mode = 1;
    for (int k = 0; k < 30; k++) begin
      nxt_addr = 21'($urandom);
      nxt_bw   = 5'($urandom_range(0, 31));
      nxt_go   = 1;
`ifdef VIDEO_SEQ_STAT_EN
      nxt_clr  = ($urandom_range(0, 7) == 0);
`endif
      ticks($urandom_range(4, 80));
`ifdef VIDEO_SEQ_STAT_EN
      nxt_clr  = 0;
`endif
      nxt_go = 0;
      ticks(4);
    end
    wait_quiet(200);

    // reset mid-burst with two reads in flight
    ack_mode = 0;
    clr_obs();
    nxt_addr = 21'($urandom); nxt_bw = {2'b11, 3'd7}; nxt_go = 1;
    wait_next(2, 100);
    tick();
    async_reset();
    clr_obs();
    nxt_go = 0;
    ticks(2);
    nxt_res = 1'b1;
    ticks(30);
    chk("t7_no_strobe", obs_strobe, 0);
    chk("t7_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
